// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash master.
// Used by spi_flash_master_param and spi_sclk_gen.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    HOLD
  } spi_state_t;

  localparam logic [7:0] CMD_PP        = 8'h02;
  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_RDSR      = 8'h05;
  localparam logic [7:0] CMD_WREN      = 8'h06;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  // Width of the per-phase bit counter; covers phases up to 256 bits.
  localparam int PHASE_CNT_W = 8;

endpackage

// File: rtl/spi_flash_master_param_sclk_gen.sv
// SCLK divider for the SPI flash master: SPI mode 3 clock (idles high)
// with a half-period of CLK_DIV clk cycles, plus single-cycle strobes
// that are high in the clk cycle whose closing edge moves sclk.
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hold,
  output logic sclk,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick     = (cnt == CW'(CLK_DIV - 1));
  assign fall_stb = en & tick & sclk;
  assign rise_stb = en & tick & ~sclk;

  // Half-period counter; in hold the final high phase is timed but sclk stays high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (tick) begin
      cnt <= '0;
      if (!hold) sclk <= ~sclk;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_flash_master_param.sv
// Parametrised SPI flash master: one transaction per start pulse
// (command, optional address, optional dummy, optional read/write data).
// Optional feature macro: SPI_FLASH_DUMMY_EN (adds dummy_cycles port and DUMMY phase).
module spi_flash_master_param
  import spi_flash_pkg::*;
#(
  parameter int CMD_WIDTH  = 8,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 2,
  parameter int NUM_CS     = 1,
  localparam int CS_SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CMD_WIDTH-1:0]  cmd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  has_addr,
  input  logic                  has_data,
  input  logic                  rd_nwr,
  input  logic [CS_SEL_W-1:0]   cs_sel,
`ifdef SPI_FLASH_DUMMY_EN
  input  logic [3:0]            dummy_cycles,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [NUM_CS-1:0]     cs_n,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso
);

  spi_state_t state_q, state_d, after_addr, after_data;

  logic [CMD_WIDTH-1:0]   cmd_sr;
  logic [ADDR_WIDTH-1:0]  addr_sr;
  logic [DATA_WIDTH-1:0]  data_sr;
  logic [PHASE_CNT_W-1:0] cnt_q, cnt_load;
  logic has_addr_q, has_data_q, rd_q, cs_valid_q;
  logic fall_stb, rise_stb, accept, last_bit, dummy_go, done_d;

`ifdef SPI_FLASH_DUMMY_EN
  logic [3:0] dummy_q;
  assign dummy_go = rd_q & has_data_q & (dummy_q != 4'd0);
`else
  assign dummy_go = 1'b0;
`endif

  assign busy     = (state_q != IDLE);
  assign accept   = (state_q == IDLE) & start;
  assign last_bit = rise_stb & (cnt_q == '0);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (busy),
    .hold     (state_q == HOLD),
    .sclk     (sclk),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Phase sequencing: phases advance on the rising edge of their last bit.
  always_comb begin
    state_d    = state_q;
    cnt_load   = '0;
    done_d     = 1'b0;
    after_data = has_data_q ? DATA : HOLD;
    after_addr = dummy_go ? DUMMY : after_data;
    case (state_q)
      IDLE:  if (start) state_d = CMD;
      CMD:   if (last_bit) state_d = has_addr_q ? ADDR : after_addr;
      ADDR:  if (last_bit) state_d = after_addr;
`ifdef SPI_FLASH_DUMMY_EN
      DUMMY: if (last_bit) state_d = DATA;
`endif
      DATA:  if (last_bit) state_d = HOLD;
      HOLD: begin
        if (fall_stb) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    case (state_d)
      CMD:   cnt_load = PHASE_CNT_W'(CMD_WIDTH - 1);
      ADDR:  cnt_load = PHASE_CNT_W'(ADDR_WIDTH - 1);
`ifdef SPI_FLASH_DUMMY_EN
      DUMMY: cnt_load = PHASE_CNT_W'(dummy_q) - PHASE_CNT_W'(1);
`endif
      DATA:  cnt_load = PHASE_CNT_W'(DATA_WIDTH - 1);
      default: cnt_load = '0;
    endcase
  end

  // Datapath: latch request, shift on sclk edges, drive cs_n/mosi, publish rdata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_sr     <= '0;
      addr_sr    <= '0;
      data_sr    <= '0;
      cnt_q      <= '0;
      has_addr_q <= 1'b0;
      has_data_q <= 1'b0;
      rd_q       <= 1'b0;
      cs_valid_q <= 1'b0;
`ifdef SPI_FLASH_DUMMY_EN
      dummy_q    <= '0;
`endif
      cs_n       <= '1;
      mosi       <= 1'b0;
      rdata      <= '0;
      done       <= 1'b0;
    end else begin
      done <= done_d;
      if (accept) begin
        cmd_sr     <= cmd;
        addr_sr    <= addr;
        data_sr    <= wdata;
        has_addr_q <= has_addr;
        has_data_q <= has_data;
        rd_q       <= rd_nwr;
        cs_valid_q <= (32'(cs_sel) < 32'(NUM_CS));
`ifdef SPI_FLASH_DUMMY_EN
        dummy_q    <= dummy_cycles;
`endif
        cnt_q      <= PHASE_CNT_W'(CMD_WIDTH - 1);
        mosi       <= cmd[CMD_WIDTH-1];
        for (int unsigned i = 0; i < NUM_CS; i++) cs_n[i] <= (32'(cs_sel) != i);
      end else begin
        if (rise_stb) begin
          cnt_q <= (state_d != state_q) ? cnt_load : cnt_q - PHASE_CNT_W'(1);
          case (state_q)
            CMD:  cmd_sr  <= cmd_sr << 1;
            ADDR: addr_sr <= addr_sr << 1;
            // Write data shifts out of the top while read data fills from miso.
            DATA: data_sr <= {data_sr[DATA_WIDTH-2:0], rd_q & miso};
            default: ;
          endcase
        end
        if (fall_stb) begin
          case (state_q)
            CMD:     mosi <= cmd_sr[CMD_WIDTH-1];
            ADDR:    mosi <= addr_sr[ADDR_WIDTH-1];
            DATA:    mosi <= ~rd_q & data_sr[DATA_WIDTH-1];
            default: mosi <= 1'b0;
          endcase
        end
        if (done_d) begin
          cs_n <= '1;
          if (rd_q && has_data_q && cs_valid_q) rdata <= data_sr;
        end
      end
    end
  end

endmodule

// File: doc/spi_flash_master_param.md
Name: spi_flash_master_param

Overview:
Parametrised next-generation SPI flash master. It runs one flash transaction per request: command phase, optional address phase, optional dummy phase, then an optional write or read data phase. Widths, SCLK divider and chip-select count are generic, and read/write direction is an explicit port. It sits between the controller FSM and the flash pins and replaces hard-coded opcode decoding with a start/busy/done handshake.

Parameters:
CMD_WIDTH, 8, command bits shifted first.
ADDR_WIDTH, 24, address bits (24 or 32).
DATA_WIDTH, 32, data phase bits.
CLK_DIV, 2, SCLK half-period in clk cycles; must be ≥1.
NUM_CS, 1, number of chip selects; CS_SEL_W = max(1, clog2(NUM_CS)).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  request pulse; accepted only while busy=0
cmd  in  CMD_WIDTH  opcode
addr  in  ADDR_WIDTH  flash address
wdata  in  DATA_WIDTH  write data
has_addr  in  1  include address phase
has_data  in  1  include data phase
rd_nwr  in  1  1 = data phase reads MISO; 0 = data phase drives wdata
cs_sel  in  CS_SEL_W  target device index
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
rdata  out  DATA_WIDTH  last read word
cs_n  out  NUM_CS  chip selects, active low
sclk  out  1  serial clock, SPI mode 3 (idles high)
mosi  out  1  master out
miso  in  1  master in

Behaviour:
- Reset (rst=0, async): cs_n all 1, sclk=1, mosi=0, busy=0, done=0, rdata=0, state IDLE. Reset mid-transfer aborts immediately; the next transfer starts clean.
- States: IDLE → CMD → ADDR (if has_addr) → DUMMY (macro only) → DATA (if has_data) → HOLD → IDLE.
- Accept: start=1 in IDLE. The same edge latches cmd, addr, wdata, flags and cs_sel, sets busy=1, drives cs_n[cs_sel]=0 and puts cmd MSB on mosi. start while busy=1 is ignored. Input changes after acceptance have no effect.
- Bit timing:
  - sclk falls CLK_DIV cycles after cs_n falls.
  - Each bit lasts 2·CLK_DIV cycles: falling edge, then rising edge.
  - mosi updates on falling edges only (except the first bit, set up at accept). Slave samples on rising edge.
  - MSB first in every phase.
- Read data: miso is sampled on each rising edge into a shift register. In DATA with rd_nwr=1, mosi=0.
- Phase change: counters reload at each phase boundary, with no idle SCLK between phases.
- HOLD: after the final rising edge, sclk stays high for CLK_DIV cycles. Then cs_n goes all 1, done=1 for one cycle, busy=0, and rdata updates in that same cycle (read only). rdata is unchanged on write and non-data transfers.
- Next transfer: start in the cycle after done is accepted.
- cs_sel ≥ NUM_CS: request is accepted, no cs_n asserts, timing is unchanged, rdata is unchanged.
- Total cs_n-low time = CLK_DIV·(1 + 2·bits), where bits = CMD_WIDTH + has_addr·ADDR_WIDTH + [dummy] + has_data·DATA_WIDTH.

Optional Feature:
- Macro: SPI_FLASH_DUMMY_EN.
- With the macro: adds input dummy_cycles[3:0]. For read transfers (rd_nwr=1, has_data=1), DUMMY inserts dummy_cycles full SCLK cycles between ADDR and DATA. mosi=0 and miso is not captured during DUMMY. A value of 0 skips DUMMY.
- Without the macro: no dummy_cycles port and no DUMMY state; behaviour is identical to the macro build with dummy_cycles=0.

Decomposition:
- Package spi_flash_pkg holds:
  - state encoding typedef (IDLE, CMD, ADDR, DUMMY, DATA, HOLD);
  - opcode constants: CMD_PP=0x02, CMD_READ=0x03, CMD_RDSR=0x05, CMD_WREN=0x06, CMD_FAST_READ=0x0B;
  - phase bit-count width localparam.
- One sub-module, spi_sclk_gen: CLK_DIV divider that emits sclk plus single-cycle fall_stb/rise_stb strobes, enabled by busy.

Test Plan:
- WREN: CLK_DIV=2, cmd=0x06, has_addr=0, has_data=0 → exactly 8 rising edges, mosi bits 00000110, cs_n[0] low 34 cycles, one done pulse.
- Page program: cmd=0x02, addr=0x123456, wdata=0xDEADBEEF, write, CLK_DIV=2 → 64 bits 02 12 34 56 DE AD BE EF on mosi, cs_n low 258 cycles, rdata stays 0.
- Read: cmd=0x03, addr=0x000100, rd_nwr=1, slave model returns 0xA5C3_0F96 → rdata=0xA5C30F96 in the done cycle, mosi=0 throughout DATA.
- Busy/reset: start re-pulsed mid-transfer → ignored, single done. Separately, rst=0 at bit 20 → cs_n=1 and sclk=1 asynchronously, no done; a following WREN completes correctly.
- NUM_CS=4 with cs_sel=2 → only cs_n[2] toggles. With SPI_FLASH_DUMMY_EN: cmd=0x0B, dummy_cycles=8 → 8 SCLK cycles between address and data, and miso bits during dummy do not appear in rdata.
